// File: rtl/crossclock_req_source.sv
// Source side of a 4-phase req/ack clock crossing: queues events in a small FIFO
// and launches one request per event, holding req_data until the ack cycle completes.
module crossclock_req_source #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned ACK_SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         evt_valid,
   input  logic [DATA_WIDTH-1:0]        evt_data,
   output logic                         evt_ready,
   output logic                         req,
   output logic [DATA_WIDTH-1:0]        req_data,
   input  logic                         ack_in,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   pending,
   output logic                         overflow,
   input  logic                         overflow_clr
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;

   state_e                       state_q, state_d;
   logic [ACK_SYNC_STAGES-1:0]   ack_sync_q, ack_sync_d;
   logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]        mem_d [DEPTH];
   logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]              count_q, count_d;
   logic                         req_q, req_d;
   logic [DATA_WIDTH-1:0]        req_data_q, req_data_d;
   logic                         overflow_q, overflow_d;

   logic ack_s;
   logic push;
   logic pop;

   assign ack_s     = ack_sync_q[ACK_SYNC_STAGES-1];
   // Full is judged on the registered count only; a pop in the same cycle does not free a slot.
   assign evt_ready = (count_q != CntW'(DEPTH));
   assign push      = evt_valid && evt_ready;
   assign pop       = (state_q == StIdle) && (count_q != '0) && !ack_s;

   assign req       = req_q;
   assign req_data  = req_data_q;
   assign pending   = count_q;
   assign overflow  = overflow_q;
   assign busy      = (state_q != StIdle) || (count_q != '0);

   always_comb begin
      ack_sync_d = {ack_sync_q[ACK_SYNC_STAGES-2:0], ack_in};
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      state_d    = state_q;
      req_d      = req_q;
      req_data_d = req_data_q;
      overflow_d = overflow_q;

      if (push) begin
         mem_d[wr_ptr_q] = evt_data;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      // Set has priority over clear so a drop in the clearing cycle is not lost.
      if (overflow_clr) overflow_d = 1'b0;
      if (evt_valid && !evt_ready) overflow_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d    = StReq;
               req_d      = 1'b1;
               req_data_d = mem_q[rd_ptr_q];
            end
         end
         StReq: begin
            if (ack_s) begin
               state_d = StRelease;
               req_d   = 1'b0;
            end
         end
         StRelease: begin
            if (!ack_s) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ack_sync_q <= '0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         req_q      <= 1'b0;
         req_data_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_sync_q <= ack_sync_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         req_q      <= req_d;
         req_data_q <= req_data_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_crossclock_req_source.sv
// Directed bench for crossclock_req_source: reset, single event, ordering,
// full/overflow, stale ack and simultaneous push/pop.
module tb_crossclock_req_source;

   logic       clk;
   logic       reset_n;
   logic       evt_valid;
   logic [7:0] evt_data;
   logic       evt_ready;
   logic       req;
   logic [7:0] req_data;
   logic       ack_in;
   logic       busy;
   logic [2:0] pending;
   logic       overflow;
   logic       overflow_clr;

   int total = 0;
   int bad   = 0;

   // ack loopback and request monitor state
   logic       loop_en = 1'b0;
   logic [3:0] hist    = '0;
   logic       mon_en  = 1'b0;
   logic       req_prev = 1'b0;
   logic [7:0] held    = '0;
   logic [7:0] pulse_data [8];
   int         npulse  = 0;
   int         low_run = 0;
   int         min_gap = 1000;
   int         stable_err = 0;

   crossclock_req_source #(
      .DATA_WIDTH      (8),
      .DEPTH           (4),
      .ACK_SYNC_STAGES (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .evt_valid    (evt_valid),
      .evt_data     (evt_data),
      .evt_ready    (evt_ready),
      .req          (req),
      .req_data     (req_data),
      .ack_in       (ack_in),
      .busy         (busy),
      .pending      (pending),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; everything is sampled/driven 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (loop_en) begin
         hist   = {hist[2:0], req};
         ack_in = hist[3];
      end
      if (mon_en) begin
         if (req && !req_prev) begin
            if (npulse < 8) pulse_data[npulse] = req_data;
            if (npulse > 0 && low_run < min_gap) min_gap = low_run;
            npulse++;
         end
         if (req && req_prev && req_data !== held) stable_err++;
         held     = req_data;
         low_run  = req ? 0 : low_run + 1;
         req_prev = req;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset_n      = 1'b1;
      evt_valid    = 1'b0;
      evt_data     = '0;
      ack_in       = 1'b0;
      overflow_clr = 1'b0;
      #3 reset_n = 1'b0;
      #1;
      check_eq("por_req",      {31'd0, req},       32'd0);
      check_eq("por_req_data", {24'd0, req_data},  32'd0);
      check_eq("por_ready",    {31'd0, evt_ready}, 32'd1);
      check_eq("por_busy",     {31'd0, busy},      32'd0);
      ticks(2);
      reset_n = 1'b1;
      ticks(2);

      // Single event with hand-driven ack
      evt_valid = 1'b1; evt_data = 8'hA5;
      tick();
      evt_valid = 1'b0;
      check_eq("single_push_pending", {29'd0, pending}, 32'd1);
      check_eq("single_req_not_yet",  {31'd0, req},     32'd0);
      tick();
      check_eq("single_req_rise", {31'd0, req},      32'd1);
      check_eq("single_req_data", {24'd0, req_data}, 32'hA5);
      check_eq("single_pending0", {29'd0, pending},  32'd0);
      ticks(3);
      ack_in = 1'b1;
      ticks(2);
      check_eq("single_req_hold", {31'd0, req}, 32'd1);
      // ack_in changes mid-cycle: two synchronizer edges, then the FSM edge drops req
      tick();
      check_eq("single_req_fall", {31'd0, req},      32'd0);
      check_eq("single_data_held", {24'd0, req_data}, 32'hA5);
      ack_in = 1'b0;
      ticks(2);
      check_eq("single_busy_release", {31'd0, busy}, 32'd1);
      tick();
      check_eq("single_busy_done", {31'd0, busy}, 32'd0);

      // Ordering with loopback ack
      hist = '0; loop_en = 1'b1; mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         evt_valid = 1'b1; evt_data = 8'(i + 1);
         tick();
      end
      evt_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (npulse >= 4 && !busy && !ack_in) break;
         tick();
      end
      check_eq("order_drained", {31'd0, busy}, 32'd0);
      check_eq("order_npulse",  npulse,        32'd4);
      for (int i = 0; i < 4; i++) check_eq("order_data", {24'd0, pulse_data[i]}, 32'(i + 1));
      check_eq("order_stable",      stable_err,             32'd0);
      check_eq("order_release_gap", {31'd0, min_gap >= 4},  32'd1);
      loop_en = 1'b0; mon_en = 1'b0; ack_in = 1'b0; hist = '0;
      ticks(3);

      // Full / overflow with ack tied low
      for (int i = 0; i < 5; i++) begin
         evt_valid = 1'b1; evt_data = 8'h10 + 8'(i);
         tick();
      end
      check_eq("full_pending",  {29'd0, pending},   32'd4);
      check_eq("full_ready",    {31'd0, evt_ready}, 32'd0);
      check_eq("full_req",      {31'd0, req},       32'd1);
      check_eq("full_req_data", {24'd0, req_data},  32'h10);
      check_eq("full_ovf_pre",  {31'd0, overflow},  32'd0);
      evt_data = 8'h15;
      tick();
      evt_valid = 1'b0;
      check_eq("ovf_set",     {31'd0, overflow}, 32'd1);
      check_eq("ovf_pending", {29'd0, pending},  32'd4);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check_eq("ovf_clr", {31'd0, overflow}, 32'd0);
      evt_valid = 1'b1; overflow_clr = 1'b1;
      tick();
      evt_valid = 1'b0; overflow_clr = 1'b0;
      check_eq("ovf_set_wins", {31'd0, overflow}, 32'd1);

      // Asynchronous reset mid-handshake, checked before any clock edge
      reset_n = 1'b0;
      #1;
      check_eq("rst_req",      {31'd0, req},       32'd0);
      check_eq("rst_req_data", {24'd0, req_data},  32'd0);
      check_eq("rst_pending",  {29'd0, pending},   32'd0);
      check_eq("rst_overflow", {31'd0, overflow},  32'd0);
      check_eq("rst_busy",     {31'd0, busy},      32'd0);
      check_eq("rst_ready",    {31'd0, evt_ready}, 32'd1);

      // Stale ack out of reset
      ack_in = 1'b1;
      ticks(2);
      reset_n = 1'b1;
      ticks(3);
      evt_valid = 1'b1; evt_data = 8'h3C;
      tick();
      evt_valid = 1'b0;
      ticks(4);
      check_eq("stale_req_blocked", {31'd0, req},     32'd0);
      check_eq("stale_pending",     {29'd0, pending}, 32'd1);
      ack_in = 1'b0;
      ticks(2);
      check_eq("stale_req_wait", {31'd0, req}, 32'd0);
      tick();
      check_eq("stale_req_rise", {31'd0, req},      32'd1);
      check_eq("stale_req_data", {24'd0, req_data}, 32'h3C);

      // Simultaneous push and pop in the launch cycle
      evt_valid = 1'b1; evt_data = 8'h77;
      tick();
      evt_valid = 1'b0;
      check_eq("pp_pending_pre", {29'd0, pending}, 32'd1);
      ack_in = 1'b1;
      ticks(3);
      check_eq("pp_req_fall", {31'd0, req}, 32'd0);
      ack_in = 1'b0;
      ticks(3);
      check_eq("pp_idle_req", {31'd0, req},  32'd0);
      check_eq("pp_idle_busy", {31'd0, busy}, 32'd1);
      evt_valid = 1'b1; evt_data = 8'h88;
      tick();
      evt_valid = 1'b0;
      check_eq("pp_pending",  {29'd0, pending},  32'd1);
      check_eq("pp_req",      {31'd0, req},      32'd1);
      check_eq("pp_req_data", {24'd0, req_data}, 32'h77);
      ack_in = 1'b1;
      ticks(3);
      ack_in = 1'b0;
      ticks(3);
      tick();
      check_eq("pp_next_req",  {31'd0, req},      32'd1);
      check_eq("pp_next_data", {24'd0, req_data}, 32'h88);
      check_eq("pp_next_pend", {29'd0, pending},  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
